// File: rtl/sd_output_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sd_output_buffer
// Purpose  : FIFO with Gray-mapped output for the sphere detector's results,
//            with almost-full, overflow and drop-count status.
// Revision : 1.0
// ============================================================================
module sd_output_buffer #(
    parameter int NUM_SYM  = 4,
    parameter int SYM_W    = 3,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int GRAY_EN  = 1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NUM_SYM*SYM_W-1:0]      InData,
    input  logic                          InValid,
    output logic [NUM_SYM*SYM_W-1:0]      OutData,
    output logic                          OutValid,
    input  logic                          i_out_ready,
    output logic                          o_almost_full,
    output logic                          o_overflow,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic [7:0]                    o_drop_count
);

    localparam int WORD_W = NUM_SYM * SYM_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_full;
    logic [WORD_W-1:0] w_head;
    logic [WORD_W-1:0] w_mapped;

    // Full/empty come from count only; pointers are equal in both states.
    assign w_full = (count_q == CNT_W'(DEPTH));
    assign w_pop  = (count_q != '0) && i_out_ready;
    assign w_push = InValid && (!w_full || w_pop);
    assign w_drop = InValid && w_full && !w_pop;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        if (w_drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge Clk) begin
        if (!Reset && w_push) begin
            mem_q[wr_ptr_q] <= InData;
        end
    end

    assign w_head = mem_q[rd_ptr_q];

    for (genvar s = 0; s < NUM_SYM; s++) begin : g_sym
        if (GRAY_EN != 0) begin : g_gray
            assign w_mapped[s*SYM_W +: SYM_W] =
                w_head[s*SYM_W +: SYM_W] ^ (w_head[s*SYM_W +: SYM_W] >> 1);
        end else begin : g_pass
            assign w_mapped[s*SYM_W +: SYM_W] = w_head[s*SYM_W +: SYM_W];
        end
    end

    assign OutValid      = (count_q != '0);
    assign OutData       = OutValid ? w_mapped : '0;
    assign o_almost_full = (count_q >= CNT_W'(AF_LEVEL));
    assign o_overflow    = overflow_q;
    assign o_count       = count_q;
    assign o_drop_count  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_output_buffer.sv
`default_nettype none
// Directed bench for sd_output_buffer: Gray and pass-through builds side by side.
module tb_sd_output_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic [11:0] out_data,  out_data_p;
    logic        out_valid, out_valid_p;
    logic        af,  af_p;
    logic        ovf, ovf_p;
    logic [3:0]  cnt, cnt_p;
    logic [7:0]  drops, drops_p;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sd_output_buffer #(.GRAY_EN(1)) dut (
        .Clk(clk), .Reset(rst), .InData(in_data), .InValid(in_valid),
        .OutData(out_data), .OutValid(out_valid), .i_out_ready(out_ready),
        .o_almost_full(af), .o_overflow(ovf), .o_count(cnt), .o_drop_count(drops)
    );

    sd_output_buffer #(.GRAY_EN(0)) dut_pass (
        .Clk(clk), .Reset(rst), .InData(in_data), .InValid(in_valid),
        .OutData(out_data_p), .OutValid(out_valid_p), .i_out_ready(out_ready),
        .o_almost_full(af_p), .o_overflow(ovf_p), .o_count(cnt_p), .o_drop_count(drops_p)
    );

    function automatic logic [11:0] gray12(input logic [11:0] b);
        logic [2:0] lut [8];
        logic [11:0] g;
        lut = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        for (int s = 0; s < 4; s++) g[s*3 +: 3] = lut[b[s*3 +: 3]];
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] q [$];
        logic [11:0] held;
        logic        will_pop;

        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_count", 32'(cnt),       32'd0);
        chk("rst_af",    32'(af),        32'd0);
        chk("rst_ovf",   32'(ovf),       32'd0);
        chk("rst_drops", 32'(drops),     32'd0);
        rst = 1'b0;

        // Single word, sink ready
        in_data = 12'h29F; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid),  32'd1);
        chk("single_gray",  32'(out_data),   32'h2D4);
        chk("single_pass",  32'(out_data_p), 32'h29F);
        step();
        chk("single_gone_valid", 32'(out_valid), 32'd0);
        chk("single_gone_count", 32'(cnt),       32'd0);

        // Fill to full with sink stalled, then overflow
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_data = 12'(i); in_valid = 1'b1;
            step();
            chk("fill_count", 32'(cnt), 32'(i));
            chk("fill_af",    32'(af),  (i >= 6) ? 32'd1 : 32'd0);
        end
        chk("fill_ovf", 32'(ovf), 32'd0);
        in_data = 12'h009;
        step();
        in_valid = 1'b0;
        chk("ovf_flag",  32'(ovf),   32'd1);
        chk("ovf_drops", 32'(drops), 32'd1);
        chk("ovf_count", 32'(cnt),   32'd8);

        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_data",  32'(out_data),  32'(gray12(12'(i))));
            step();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_count", 32'(cnt),       32'd0);

        // Full with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_data = 12'(12'h010 + i); in_valid = 1'b1;
            step();
        end
        chk("refill_count", 32'(cnt), 32'd8);
        in_data = 12'h00A; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fullpp_count", 32'(cnt),   32'd8);
        chk("fullpp_drops", 32'(drops), 32'd1);
        for (int i = 2; i <= 8; i++) begin
            chk("fullpp_drain", 32'(out_data), 32'(gray12(12'(12'h010 + i))));
            step();
        end
        chk("fullpp_last", 32'(out_data), 32'(gray12(12'h00A)));
        step();
        chk("fullpp_empty", 32'(out_valid), 32'd0);

        // Push every cycle with ready toggling 1,0,1,0...
        for (int k = 0; k < 6; k++) begin
            in_data = 12'(12'h100 + k); in_valid = 1'b1;
            out_ready = ((k % 2) == 0);
            held = out_data;
            will_pop = out_valid && out_ready;
            if (q.size() != 0) chk("toggle_head", 32'(out_data), 32'(gray12(q[0])));
            step();
            if (will_pop) void'(q.pop_front());
            else if (k != 0) chk("toggle_stable", 32'(out_data), 32'(held));
            q.push_back(12'(12'h100 + k));
        end
        chk("toggle_count", 32'(cnt), 32'd4);
        chk("toggle_head_final", 32'(out_data), 32'(gray12(12'h102)));

        // Fifth word, then reset while pushing
        in_data = 12'h106; in_valid = 1'b1; out_ready = 1'b0;
        step();
        chk("pre_rst_count", 32'(cnt), 32'd5);
        chk("pre_rst_ovf",   32'(ovf), 32'd1);
        rst = 1'b1; in_data = 12'h3FF;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(cnt),       32'd0);
        chk("midrst_ovf",   32'(ovf),       32'd0);
        chk("midrst_drops", 32'(drops),     32'd0);
        chk("midrst_data",  32'(out_data),  32'd0);
        step();
        chk("midrst_lost", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
